// File: rtl/pwm_multi_analyzer.sv
// Multi-channel PWM high-pulse width analyzer: per-channel synchroniser, width FSM,
// hysteretic NONE/LOW/MID/HIGH classification, dead-channel timeout and width read-back.
module pwm_multi_analyzer #(
  parameter int N_CH      = 4,
  parameter int CNT_W     = 12,
  parameter int MAX_COUNT = 2000,
  parameter int HIGH_TH   = 1900,
  parameter int LOW_TH    = 1100,
  parameter int HYST      = 20,
  parameter int TO_W      = 16,
  parameter int TIMEOUT   = 25000,
  parameter int SEL_W     = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [N_CH-1:0]     pwm_in,
  input  logic [SEL_W-1:0]    rd_sel,
  output logic [2*N_CH-1:0]   cls,
  output logic [N_CH-1:0]     meas_vld,
  output logic [N_CH-1:0]     ovf,
  output logic [CNT_W-1:0]    rd_width
);

  typedef enum logic {IDLE = 1'b0, MEAS = 1'b1} state_t;

  localparam logic [1:0] CLS_NONE = 2'b00;
  localparam logic [1:0] CLS_LOW  = 2'b01;
  localparam logic [1:0] CLS_MID  = 2'b10;
  localparam logic [1:0] CLS_HIGH = 2'b11;

  logic [N_CH-1:0]  sync_p0, sync_p1, sync_p2;
  logic             vld_p0, vld_p1, vld_p2;
  logic [N_CH-1:0]  rise, fall, tmo;
  logic [N_CH-1:0]  lat_p1;
  state_t           state_q [N_CH];
  state_t           state_d [N_CH];
  logic [CNT_W-1:0] cnt_q   [N_CH];
  logic [CNT_W-1:0] width_q [N_CH];
  logic [TO_W-1:0]  to_cnt_q [N_CH];
  logic [CNT_W-1:0] rd_mux;

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
    return (v >= CNT_W'(MAX_COUNT)) ? CNT_W'(MAX_COUNT) : v + 1'b1;
  endfunction

  function automatic logic [TO_W-1:0] to_inc(input logic [TO_W-1:0] v);
    return (v >= TO_W'(TIMEOUT)) ? TO_W'(TIMEOUT) : v + 1'b1;
  endfunction

  function automatic logic [1:0] classify(input logic [CNT_W-1:0] w, input logic [1:0] p);
    if (p == CLS_HIGH && w >= CNT_W'(HIGH_TH - HYST)) return CLS_HIGH;
    if (p == CLS_LOW  && w <= CNT_W'(LOW_TH + HYST))  return CLS_LOW;
    if (w >= CNT_W'(HIGH_TH)) return CLS_HIGH;
    if (w <= CNT_W'(LOW_TH))  return CLS_LOW;
    return CLS_MID;
  endfunction

  // Edges are masked until the third flop holds a real pad sample, so a pad that is
  // already high when reset releases is not mistaken for a fresh rise.
  assign rise = sync_p1 & ~sync_p2 & {N_CH{vld_p2}};
  assign fall = ~sync_p1 & sync_p2;

  always_comb begin
    tmo = '0;
    for (int i = 0; i < N_CH; i++) begin
      tmo[i]     = (to_cnt_q[i] == TO_W'(TIMEOUT)) && !rise[i];
      state_d[i] = state_q[i];
      if (!en)                                 state_d[i] = IDLE;
      else if (state_q[i] == IDLE && rise[i])  state_d[i] = MEAS;
      else if (tmo[i])                         state_d[i] = IDLE;
      else if (state_q[i] == MEAS && fall[i])  state_d[i] = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) state_q[i] <= IDLE;
    end else begin
      for (int i = 0; i < N_CH; i++) state_q[i] <= state_d[i];
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < N_CH; i++)
      if (SEL_W'(i) == rd_sel) rd_mux = width_q[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0  <= '0;
      sync_p1  <= '0;
      sync_p2  <= '0;
      vld_p0   <= 1'b0;
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      lat_p1   <= '0;
      cls      <= '0;
      meas_vld <= '0;
      ovf      <= '0;
      rd_width <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i]    <= '0;
        width_q[i]  <= '0;
        to_cnt_q[i] <= '0;
      end
    end else begin
      // p0 -> p2: synchroniser and edge-detect stages
      sync_p0 <= pwm_in;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
      vld_p0  <= 1'b1;
      vld_p1  <= vld_p0;
      vld_p2  <= vld_p1;
      for (int i = 0; i < N_CH; i++) begin
        meas_vld[i] <= 1'b0;
        lat_p1[i]   <= 1'b0;
        if (!en) begin
          to_cnt_q[i]  <= '0;
          cls[2*i +: 2] <= CLS_NONE;
        end else begin
          to_cnt_q[i] <= rise[i] ? '0 : to_inc(to_cnt_q[i]);
          // p1: width was latched last cycle, strobe and reclassify now
          if (lat_p1[i]) begin
            meas_vld[i]   <= 1'b1;
            cls[2*i +: 2] <= classify(width_q[i], cls[2*i +: 2]);
          end
          if (tmo[i]) begin
            meas_vld[i]   <= 1'b0;
            cls[2*i +: 2] <= CLS_NONE;
          end
          if (state_q[i] == IDLE) begin
            if (rise[i]) cnt_q[i] <= CNT_W'(1);
          end else if (!tmo[i]) begin
            if (fall[i]) begin
              width_q[i] <= cnt_q[i];
              ovf[i]     <= (cnt_q[i] == CNT_W'(MAX_COUNT));
              lat_p1[i]  <= 1'b1;
            end else if (sync_p1[i]) begin
              cnt_q[i] <= cnt_inc(cnt_q[i]);
            end
          end
        end
      end
      rd_width <= rd_mux;
    end
  end

endmodule

// File: tb/tb_pwm_multi_analyzer.sv
// Directed bench for pwm_multi_analyzer: table of single-pulse vectors plus hand-written
// sequences for timeout, mid-pulse reset, enable toggling and read-back latency.
module tb_pwm_multi_analyzer;
  localparam int N_CH = 4;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [3:0]  pwm_in;
  logic [1:0]  rd_sel;
  logic [7:0]  cls;
  logic [3:0]  meas_vld, ovf;
  logic [11:0] rd_width;

  int tests = 0;
  int fails = 0;
  int vld_cnt [N_CH] = '{default: 0};

  typedef struct {
    int ch;
    int hi;
    int w;
    int c;
    int o;
  } vec_t;
  vec_t vt [12];

  pwm_multi_analyzer dut (
    .clk(clk), .rst(rst), .en(en), .pwm_in(pwm_in), .rd_sel(rd_sel),
    .cls(cls), .meas_vld(meas_vld), .ovf(ovf), .rd_width(rd_width)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    for (int c = 0; c < N_CH; c++)
      if (meas_vld[c] === 1'b1) vld_cnt[c]++;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int ch, input int n);
    cycles(1);
    pwm_in[ch] = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    pwm_in[ch] = 1'b0;
  endtask

  function automatic int total_vld();
    int s = 0;
    for (int c = 0; c < N_CH; c++) s += vld_cnt[c];
    return s;
  endfunction

  task automatic run_vec(input string tag, input int ch, input int hi,
                         input int w, input int c, input int o);
    int n;
    int cs;
    n  = 0;
    cs = -1;
    rd_sel = 2'(ch);
    pulse(ch, hi);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (meas_vld[ch]) begin
        n++;
        cs = int'(cls[2*ch +: 2]);
      end
    end
    check({tag, "_strobes"}, n, 1);
    check({tag, "_cls"}, cs, c);
    check({tag, "_ovf"}, int'(ovf[ch]), o);
    check({tag, "_width"}, int'(rd_width), w);
  endtask

  initial begin
    int v;
    vt[0]  = '{0, 1500, 1500, 2, 0};
    vt[1]  = '{1, 1950, 1950, 3, 0};
    vt[2]  = '{1, 1890, 1890, 3, 0};
    vt[3]  = '{1, 1870, 1870, 2, 0};
    vt[4]  = '{2, 1000, 1000, 1, 0};
    vt[5]  = '{2, 1115, 1115, 1, 0};
    vt[6]  = '{2, 1125, 1125, 2, 0};
    vt[7]  = '{2, 1,    1,    1, 0};
    vt[8]  = '{3, 2000, 2000, 3, 1};
    vt[9]  = '{3, 1999, 1999, 3, 0};
    vt[10] = '{3, 3000, 2000, 3, 1};
    vt[11] = '{0, 1100, 1100, 1, 0};

    rst = 1'b1; en = 1'b1; pwm_in = '0; rd_sel = '0;
    repeat (3) @(negedge clk);
    check("rst_cls", int'(cls), 0);
    check("rst_vld", int'(meas_vld), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_rdw", int'(rd_width), 0);
    cycles(1);
    rst = 1'b0;
    cycles(5);

    for (int k = 0; k < 12; k++) begin
      run_vec($sformatf("v%0d", k), vt[k].ch, vt[k].hi, vt[k].w, vt[k].c, vt[k].o);
      if (k == 0) check("v0_others_cls", int'(cls[7:2]), 0);
    end

    // read-back latency: old value until the next clock edge
    cycles(1);
    rd_sel = 2'd1;
    @(negedge clk);
    check("rdsel_before", int'(rd_width), 1100);
    @(negedge clk);
    check("rdsel_after", int'(rd_width), 1870);

    // ch0 stuck low and ch1 stuck high until timeout
    cycles(1);
    pwm_in[1] = 1'b1;
    run_vec("to_pre", 0, 1500, 1500, 2, 0);
    cycles(23000);
    @(negedge clk);
    check("to_before_cls0", int'(cls[1:0]), 2);
    cycles(2000);
    @(negedge clk);
    check("to_after_cls0", int'(cls[1:0]), 0);
    check("to_after_cls1", int'(cls[3:2]), 0);
    check("to_width_kept", int'(rd_width), 1500);
    cycles(1);
    v = vld_cnt[1];
    pwm_in[1] = 1'b0;
    cycles(20);
    check("stuck_hi_fall_vld", vld_cnt[1], v);
    check("stuck_hi_cls", int'(cls[3:2]), 0);
    rd_sel = 2'd1;
    cycles(2);
    check("stuck_hi_width", int'(rd_width), 1870);
    run_vec("to_post", 0, 1500, 1500, 2, 0);

    // asynchronous reset in the middle of a ch0 pulse
    check("ovf_pre_rst", int'(ovf[3]), 1);
    rd_sel = 2'd0;
    cycles(1);
    pwm_in[0] = 1'b1;
    cycles(700);
    #2 rst = 1'b1;
    #1;
    check("arst_cls", int'(cls), 0);
    check("arst_ovf", int'(ovf), 0);
    check("arst_rdw", int'(rd_width), 0);
    check("arst_vld", int'(meas_vld), 0);
    cycles(2);
    rst = 1'b0;
    v = vld_cnt[0];
    cycles(300);
    pwm_in[0] = 1'b0;
    cycles(20);
    check("arst_fall_vld", vld_cnt[0], v);
    check("arst_fall_cls", int'(cls[1:0]), 0);
    check("arst_fall_rdw", int'(rd_width), 0);
    run_vec("arst_next", 0, 1200, 1200, 2, 0);

    // enable dropped mid-pulse, re-raised while inputs are high
    cycles(1);
    v = total_vld();
    pwm_in = 4'hF;
    cycles(500);
    en = 1'b0;
    cycles(2);
    check("en_low_cls", int'(cls), 0);
    pwm_in = 4'h0;
    cycles(100);
    pwm_in = 4'hF;
    cycles(100);
    en = 1'b1;
    cycles(300);
    pwm_in = 4'h0;
    cycles(20);
    check("en_no_vld", total_vld(), v);
    check("en_cls_zero", int'(cls), 0);
    check("en_width_kept", int'(rd_width), 1200);
    run_vec("en_next", 2, 800, 800, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
